// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the buffered entry layout and the credit-counter sizing helper.
package fetch_pkg;

    localparam int unsigned FETCH_AW        = 32;
    localparam int unsigned FETCH_BUF_DEPTH = 2;
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_AW-1:0] pc;
        logic [31:0]         instr;
    } fetch_entry_t;

    function automatic int unsigned cred_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned CRED_W = cred_w(FETCH_BUF_DEPTH);

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// Flush wins over push and pop; head is read combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_BUF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  fetch_entry_t         din,
    output logic                 full,
    output logic                 empty,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t         head
);

    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem_q[rd_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Pointer and occupancy next-state, flush clears everything.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PW'(1);
            if (do_pop)  rd_d = rd_q + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + (PW+1)'(1);
                2'b01:   cnt_d = cnt_q - (PW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer/occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage needs no reset; occupancy guards reads.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues credit-limited in-order requests.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W    = FETCH_AW,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       BUF_DEPTH = FETCH_BUF_DEPTH,
    parameter int unsigned       CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    input  logic              stall_d,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              valid_f,
    output logic [31:0]       instr_f,
    output logic [ADDR_W-1:0] pc_f,
    output logic [ADDR_W-1:0] pc_plus4_f
`ifdef FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_fetched,
    output logic [CNT_W-1:0]  perf_stall_cycles
`endif
);

    localparam int unsigned CW =
        (BUF_DEPTH == FETCH_BUF_DEPTH) ? CRED_W : cred_w(BUF_DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [ADDR_W-1:0] redir_pc;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     buf_cnt;
    logic [CW:0]       used;
    logic [CW:0]       inflight;
    logic              accept;
    logic              resp_live;
    logic              fifo_push;
    logic              fifo_pop;
    logic              buf_full;
    logic              buf_empty;
    fetch_entry_t      din;
    fetch_entry_t      head;
    logic              unused_bits;

    assign redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign inflight = {1'b0, outst_q} + {1'b0, drop_q};
    assign used     = inflight + {1'b0, buf_cnt};

    assign imem_req_valid = rst && !redirect_valid
                          && (used < (CW+1)'(BUF_DEPTH));
    assign imem_addr      = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response with nothing in flight is stale memory state; ignore it.
    assign resp_live = imem_resp_valid && (inflight != '0);
    assign fifo_push = resp_live && (drop_q == '0) && !redirect_valid;
    assign fifo_pop  = valid_f && !stall_d && !redirect_valid;
    assign din       = '{pc: resp_pc_q, instr: imem_resp_data};

    assign valid_f    = !buf_empty;
    assign instr_f    = valid_f ? head.instr : NOP_INSTR;
    assign pc_f       = valid_f ? head.pc : '0;
    assign pc_plus4_f = pc_f + ADDR_W'(4);

    assign unused_bits = ^{redirect_pc[1:0], buf_full};

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .din   (din),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_cnt),
        .head  (head)
    );

    // PC, response-tag and credit bookkeeping; redirect overrides all.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            fetch_pc_d = redir_pc;
            resp_pc_d  = redir_pc;
            outst_d    = '0;
            drop_d     = drop_q + outst_q - CW'(resp_live);
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            if (resp_live && (drop_q != '0)) drop_d = drop_q - CW'(1);
            if (fifo_push) resp_pc_d = resp_pc_q + ADDR_W'(4);
            outst_d = outst_q + CW'(accept) - CW'(fifo_push);
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] fetched_q;
    logic [CNT_W-1:0] stalls_q;

    assign perf_fetched      = fetched_q;
    assign perf_stall_cycles = stalls_q;

    // Saturating counters for consumed words and stalled-valid cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else begin
            if (fifo_pop && (fetched_q != '1))
                fetched_q <= fetched_q + CNT_W'(1);
            if (valid_f && stall_d && (stalls_q != '1))
                stalls_q <= stalls_q + CNT_W'(1);
        end
    end
`else
    logic unused_perf;
    assign unused_perf = (CNT_W == 0);
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model, directed table, scoreboard.
// Perf counter checks are compiled when FETCH_PERF_EN is defined.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        stall_d = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        valid_f;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cycles;
`endif

    instr_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .stall_d         (stall_d),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .valid_f         (valid_f),
        .instr_f         (instr_f),
        .pc_f            (pc_f),
        .pc_plus4_f      (pc_plus4_f)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    typedef struct {
        bit          stall;
        bit          redir;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_vf;
        logic [31:0] e_pc;
    } vec_t;

    mem_t        mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr = '0;
    vec_t        tbl[18];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    int          lat = 1;
    bit          rand_ready = 1'b0;
    int          tb_cons = 0;
    int          tb_stall = 0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic bad(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic vec_t mk(bit s, bit r, logic [31:0] rp, bit er,
                                logic [31:0] ea, bit ev, logic [31:0] ep);
        vec_t v;
        v.stall = s; v.redir = r; v.rpc = rp;
        v.e_req = er; v.e_addr = ea; v.e_vf = ev; v.e_pc = ep;
        return v;
    endfunction

    // Let inputs settle, then update the memory and scoreboard models.
    task automatic settle_mon();
        logic [31:0] e;
        mem_t        m;
        #1;
        if (!rst) begin
            exp_q.delete();
            exp_addr  = '0;
            prev_hold = 1'b0;
            tb_cons   = 0;
            tb_stall  = 0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", valid_f, 1);
                chk("hold_pc", pc_f, prev_pc);
                chk("hold_instr", instr_f, prev_instr);
            end
            if (dut.u_fifo.full) chk("push_when_full", dut.fifo_push, 0);
            if (valid_f && stall_d) tb_stall++;
            if (redirect_valid) begin
                chk("req_in_redirect", imem_req_valid, 0);
                exp_q.delete();
                exp_addr = {redirect_pc[31:2], 2'b00};
            end else begin
                if (valid_f && !stall_d) begin
                    tb_cons++;
                    if (exp_q.size() == 0) begin
                        bad("sb_underflow", pc_f, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc", pc_f, e);
                        chk("sb_instr", instr_f, ~e);
                        chk("sb_pc4", pc_plus4_f, e + 32'd4);
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    chk("req_addr", imem_addr, exp_addr);
                    m.addr = imem_addr;
                    m.due  = cyc_n + lat;
                    mem_q.push_back(m);
                    exp_q.push_back(exp_addr);
                    exp_addr = exp_addr + 32'd4;
                end
            end
            prev_hold  = valid_f && stall_d && !redirect_valid;
            prev_pc    = pc_f;
            prev_instr = instr_f;
        end
    endtask

    // Clock edge, then drive the memory response and ready for next cycle.
    task automatic edge_step();
        @(posedge clk);
        #1;
        cyc_n++;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (!rst) begin
            mem_q.delete();
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc_n) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = ~mem_q[0].addr;
            void'(mem_q.pop_front());
        end
        imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        stall_d = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) begin
            settle_mon();
            edge_step();
        end
        settle_mon();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_valid_f", valid_f, 0);
        chk("rst_instr", instr_f, 32'h0000_0013);
        chk("rst_pc", pc_f, 32'h0);
        chk("rst_pc4", pc_plus4_f, 32'h4);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched, 0);
        chk("rst_perf_stall", perf_stall_cycles, 0);
`endif
        edge_step();
        rst = 1'b1;
    endtask

    initial begin
        bit found;
        int start;

        tbl[0]  = mk(0, 0, 0,       1, 32'h00,  0, 0);
        tbl[1]  = mk(0, 0, 0,       1, 32'h04,  0, 0);
        tbl[2]  = mk(0, 0, 0,       0, 0,       1, 32'h00);
        tbl[3]  = mk(0, 0, 0,       1, 32'h08,  1, 32'h04);
        tbl[4]  = mk(0, 0, 0,       1, 32'h0C,  0, 0);
        tbl[5]  = mk(0, 0, 0,       0, 0,       1, 32'h08);
        tbl[6]  = mk(1, 0, 0,       1, 32'h10,  1, 32'h0C);
        tbl[7]  = mk(1, 0, 0,       0, 0,       1, 32'h0C);
        tbl[8]  = mk(1, 0, 0,       0, 0,       1, 32'h0C);
        tbl[9]  = mk(1, 0, 0,       0, 0,       1, 32'h0C);
        tbl[10] = mk(1, 0, 0,       0, 0,       1, 32'h0C);
        tbl[11] = mk(0, 0, 0,       0, 0,       1, 32'h0C);
        tbl[12] = mk(0, 0, 0,       1, 32'h14,  1, 32'h10);
        tbl[13] = mk(0, 0, 0,       1, 32'h18,  0, 0);
        tbl[14] = mk(1, 1, 32'h103, 0, 0,       1, 32'h14);
        tbl[15] = mk(0, 0, 0,       1, 32'h100, 0, 0);
        tbl[16] = mk(0, 0, 0,       1, 32'h104, 0, 0);
        tbl[17] = mk(0, 0, 0,       0, 0,       1, 32'h100);

        lat = 1;
        rand_ready = 1'b0;
        do_reset();

        for (int i = 0; i < 18; i++) begin
            stall_d        = tbl[i].stall;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            settle_mon();
            chk($sformatf("t%0d_req", i), imem_req_valid, tbl[i].e_req);
            if (tbl[i].e_req)
                chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("t%0d_vf", i), valid_f, tbl[i].e_vf);
            if (tbl[i].e_vf)
                chk($sformatf("t%0d_pc", i), pc_f, tbl[i].e_pc);
            edge_step();
        end
        stall_d = 1'b0;
        redirect_valid = 1'b0;

        lat = 3;
        do_reset();
        repeat (2) begin
            settle_mon();
            edge_step();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        settle_mon();
        edge_step();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            settle_mon();
            if (valid_f) begin
                found = 1'b1;
                chk("redir_first_pc", pc_f, 32'h100);
            end
            edge_step();
        end
        if (!found) bad("redir_timeout", 0, 1);

        rand_ready = 1'b1;
        start = tb_cons;
        for (int k = 0; k < 400; k++) begin
            stall_d        = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = 32'($urandom_range(0, 1023));
            settle_mon();
            edge_step();
        end
        stall_d = 1'b0;
        redirect_valid = 1'b0;
        chk("rand_progress", (tb_cons - start) >= 20, 1);
`ifdef FETCH_PERF_EN
        chk("rand_perf_fetched", perf_fetched, tb_cons);
        chk("rand_perf_stall", perf_stall_cycles, tb_stall);
`endif

        settle_mon();
        edge_step();
        rand_ready = 1'b0;
        lat = 1;
        do_reset();

`ifdef FETCH_PERF_EN
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            stall_d = (tb_cons >= 4) && (tb_stall < 3);
            settle_mon();
            edge_step();
            if (tb_cons == 10) found = 1'b1;
        end
        if (!found) bad("perf_timeout", tb_cons, 10);
        chk("perf_fetched", perf_fetched, 10);
        chk("perf_stall", perf_stall_cycles, 3);
        stall_d = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of decode. Owns the PC, issues in-order requests to instruction memory (BRAM or cache) and buffers returned words.
- Presents {instr, pc, pc_plus4} plus a valid flag to decode. These feed the data_fetch_io fields that decode consumes.
- Handles decode stalls and execute-stage redirects (branch/jump), discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- ADDR_W, 32, width of PC and memory address.
- BUF_DEPTH, 2, fetch buffer entries; also the cap on outstanding requests plus buffered entries (power of 2, ≥2).
- CNT_W, 32, performance counter width (used only with FETCH_PERF_EN).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  ADDR_W  byte address, word-aligned.
- imem_resp_valid  in  1  response word valid. Responses are in order, at least 1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- stall_d  in  1  decode cannot accept this cycle.
- redirect_valid  in  1  control-flow redirect from execute.
- redirect_pc  in  ADDR_W  redirect target.
- valid_f  out  1  instr_f/pc_f/pc_plus4_f are valid.
- instr_f  out  32  instruction to decode.
- pc_f  out  ADDR_W  PC of instr_f.
- pc_plus4_f  out  ADDR_W  pc_f + 4, wraps modulo 2^ADDR_W.

Behaviour:
- Reset (rst==0 at a clock edge):
  - fetch_pc = RESET_PC; buffer empty; outstanding = 0; drop_cnt = 0.
  - valid_f = 0, instr_f = 32'h0000_0013 (NOP), pc_f = 0, pc_plus4_f = 4, imem_req_valid = 0.
  - Reset asserted mid-operation abandons all in-flight state. Memory must also be reset, or its responses are ignored while drop_cnt is 0 and the buffer is empty after reset.
- Credit:
  - imem_req_valid = rst && !redirect_valid && (outstanding + buf_count + drop_cnt) < BUF_DEPTH.
  - imem_addr = fetch_pc.
  - On accept (valid && ready): fetch_pc += 4 and outstanding += 1.
  - Address is held stable while valid && !ready, unless a redirect occurs.
- Response:
  - If drop_cnt > 0, the word is discarded and drop_cnt -= 1.
  - Otherwise it is pushed into the buffer tagged with its request PC (tracked by an in-flight PC FIFO or counter).
  - outstanding -= 1 in both cases.
  - Overflow cannot occur because of the credit rule. The bench asserts no push when full.
- Output:
  - valid_f = buffer non-empty; outputs come from the buffer head, combinationally.
  - Consume when valid_f && !stall_d && !redirect_valid.
  - Fetch-to-decode latency when the buffer is empty: one cycle after imem_resp_valid.
  - With the buffer empty, a push and a pop never occur in the same cycle. With the buffer non-empty, simultaneous push and pop are allowed.
- Stall: the head is held and all outputs are stable. Requests continue until credit is exhausted.
- Redirect (highest priority):
  - Same cycle: buffer flushed; imem_req_valid forced to 0; fetch_pc <= redirect_pc.
  - drop_cnt <= drop_cnt + outstanding − (imem_resp_valid ? 1 : 0). A response arriving in the redirect cycle is discarded.
  - valid_f shows the old head combinationally in the redirect cycle. Decode must qualify it with redirect.
  - Fetching resumes next cycle from redirect_pc.
- Back-to-back redirects: the last one wins, and drop_cnt accumulates.
- redirect_pc[1:0] != 0: bits [1:0] are forced to 0 (no misaligned-fetch trap in this core).

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds outputs perf_fetched (count of instructions consumed by decode) and perf_stall_cycles (cycles with valid_f && stall_d), both CNT_W.
  - Both reset to 0 and saturate at all-ones.
- Undefined: the ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - Typedef fetch_entry_t {logic [ADDR_W-1:0] pc; logic [31:0] instr;}.
  - Credit-count width as localparam $clog2(BUF_DEPTH)+1.
- Sub-module fetch_fifo:
  - Synchronous, parameterised depth, fetch_entry_t payload.
  - Ports: push, pop, flush, full, empty, count, head.
  - Flush has priority over push and pop.

Test Plan:
- Reset release, ready=1, 1-cycle memory latency -> requests at 0x0, 0x4, 0x8…; valid_f first high 2 cycles after reset deasserts, pc_f=0x0, pc_plus4_f=0x4.
- stall_d held 5 cycles with the buffer full -> imem_req_valid=0, outputs unchanged, no push when full.
- Redirect to 0x100 with 2 requests outstanding -> both responses dropped, next valid_f has pc_f=0x100.
- Redirect in the same cycle as a response and as stall_d=1 -> response discarded, buffer empty next cycle, fetch_pc=0x100.
- imem_req_ready toggling randomly with 3-cycle latency -> PC sequence contiguous, no duplicates or gaps, order preserved.
- FETCH_PERF_EN: 10 consumes and 3 stall cycles -> perf_fetched=10, perf_stall_cycles=3.
